banked_data_memory: RTL and testbench
=====================================

BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, byte-address width; byte capacity 2^ADDR_WIDTH; legal values >= 2.
REQ-002 SHALL have parameter WORDS, default 2^(ADDR_WIDTH-1), number of 16-bit words in the single-port array.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port reqValid  input  1  request present.
REQ-007 SHALL have port reqReady  output  1  request accepted this cycle when reqValid also high.
REQ-008 SHALL have port wrEnable  input  1  1 = write, 0 = read; sampled at accept.
REQ-009 SHALL have port numberOfByte  input  2  00 word (16-bit), 01 byte zero-ext, 10 byte sign-ext, 11 illegal.
REQ-010 SHALL have port address  input  ADDR_WIDTH  byte address, little-endian.
REQ-011 SHALL have port wrData  input  16  write data; byte modes use wrData[7:0].
REQ-012 SHALL have port rdData  output  16  registered read result.
REQ-013 SHALL have port rdValid  output  1  one-cycle pulse qualifying rdData.
REQ-014 SHALL have port err  output  1  one-cycle pulse for an illegal request.

Function
REQ-015 SHALL store bytes in 16-bit words: byte a lives in word a>>1, lane a[0] (lane 0 = bits 7:0); one word access per clock, per-lane write enables, no read-modify-write.
REQ-016 SHALL implement FSM states IDLE and SPLIT; reqReady = 1 in IDLE, 0 in SPLIT.
REQ-017 Accept occurs at the rising edge where reqValid && reqReady; inputs are captured at that edge.
REQ-018 Byte write (01/10): edge of accept writes wrData[7:0] to byte address; stay IDLE.
REQ-019 Aligned word write (00, address[0]=0): accept edge writes both lanes of word address>>1; stay IDLE.
REQ-020 Aligned word or byte read: accept edge reads word; rdData and rdValid=1 valid the cycle after accept; latency 1; throughput 1 request/cycle.
REQ-021 Byte read result: 01 -> {8'h00, byte}; 10 -> {8{byte[7]}, byte}.
REQ-022 Misaligned word (00, address[0]=1): accept edge accesses lane 1 of word w=address>>1 (low byte); FSM -> SPLIT; next edge accesses lane 0 of word (w+1) mod WORDS (high byte); FSM -> IDLE.
REQ-023 Misaligned read SHALL hold the low byte internally and assert rdValid with the full 16-bit result the cycle after the SPLIT edge (latency 2).
REQ-024 Address wrap: byte (2^ADDR_WIDTH - 1) + 1 SHALL wrap to byte 0; no error.
REQ-025 numberOfByte=11: no memory change, no rdValid; err=1 the cycle after accept; stays IDLE.
REQ-026 rdValid and err SHALL be single-cycle pulses; rdData SHALL hold its last value while rdValid=0.
REQ-027 A read accepted the edge after a write to the same byte(s) SHALL return the new data.
REQ-028 Inputs while reqReady=0 SHALL be ignored; the requester SHALL hold them until accept.

Reset
REQ-029 rst_n low SHALL immediately force FSM=IDLE, rdValid=0, err=0, rdData=16'h0000; reqReady=1 once FSM is IDLE.
REQ-030 Array contents SHALL NOT be cleared by reset; simulation initial contents are all zero.
REQ-031 Reset during SPLIT SHALL abort: low byte of a misaligned write stays committed, high byte is not written; a pending misaligned read produces no rdValid.

Verification
REQ-032 Reset; write 00 addr 2 data 16'h1294; read 00 addr 2 -> rdData=16'h1294, rdValid one cycle after accept.
REQ-033 Read of byte 2 (16'h94) -> mode 01 gives 16'h0094; mode 10 gives 16'hFF94; back-to-back accepts, reqReady stays 1.
REQ-034 Write 00 addr 5 data 16'hABCD -> reqReady low one cycle; byte5=CD, byte6=AB; read 00 addr 5 -> 16'hABCD at latency 2; byte 4 unchanged.
REQ-035 Write 00 addr 255 data 16'h5678 (ADDR_WIDTH=8) -> byte255=78, byte0=56; read 00 addr 255 -> 16'h5678.
REQ-036 Request numberOfByte=11 -> err pulse one cycle, rdValid=0, memory unchanged.
REQ-037 Misaligned write 16'hBEEF addr 7, rst_n low during SPLIT -> byte7=EF, byte8 unchanged, rdValid=0, reqReady=1 after release.

Source files
------------

// File: rtl/banked_data_memory.sv
// Byte-addressable data memory built from two 8-bit lanes of 16-bit words.
// Misaligned word accesses are split over two cycles through the SPLIT state.
module banked_data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORDS      = 2**(ADDR_WIDTH-1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  wrEnable,
  input  logic [1:0]            numberOfByte,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [15:0]           wrData,
  output logic [15:0]           rdData,
  output logic                  rdValid,
  output logic                  err
);

  localparam int IW    = ADDR_WIDTH-1;
  localparam int LANES = 2;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                      state, next_state;
  logic                        accept, misaligned, illegal;
  logic [IW-1:0]               req_word, req_next, split_word;
  logic                        split_wr;
  logic [7:0]                  split_hi, lo_byte, sel_byte;
  logic [15:0]                 read_fmt;
  logic [LANES-1:0]            lane_we;
  logic [LANES-1:0][IW-1:0]    lane_idx;
  logic [LANES-1:0][7:0]       lane_wdata, lane_rdata;

  assign reqReady   = (state == IDLE);
  assign accept     = reqValid && reqReady;
  assign illegal    = (numberOfByte == 2'b11);
  assign misaligned = (numberOfByte == 2'b00) && address[0];
  assign req_word   = address[ADDR_WIDTH-1:1];
  // high byte of a misaligned word lives in the next word, wrapping at the top
  assign req_next   = (req_word == IW'(WORDS-1)) ? '0 : req_word + IW'(1);

  // one single-port byte array per lane; contents survive reset
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [WORDS];
    always_ff @(posedge clk)
      if (lane_we[l]) mem[lane_idx[l]] <= lane_wdata[l];
    assign lane_rdata[l] = mem[lane_idx[l]];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next_state;

  always_comb begin
    next_state    = state;
    lane_we       = '0;
    lane_idx[0]   = req_word;
    lane_idx[1]   = req_word;
    lane_wdata[0] = wrData[7:0];
    lane_wdata[1] = wrData[7:0];
    case (state)
      IDLE: if (accept && !illegal) begin
        if (numberOfByte == 2'b00 && !address[0]) begin
          lane_wdata[1] = wrData[15:8];
          lane_we       = {LANES{wrEnable}};
        end else if (misaligned) begin
          lane_we[1] = wrEnable;
          next_state = SPLIT;
        end else begin
          lane_we[address[0]] = wrEnable;
        end
      end
      SPLIT: begin
        lane_idx[0]   = split_word;
        lane_wdata[0] = split_hi;
        lane_we[0]    = split_wr;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_byte = lane_rdata[address[0]];
    read_fmt = '0;
    case (numberOfByte)
      2'b00:   read_fmt = {lane_rdata[1], lane_rdata[0]};
      2'b01:   read_fmt = {8'h00, sel_byte};
      2'b10:   read_fmt = {{8{sel_byte[7]}}, sel_byte};
      default: read_fmt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdValid    <= 1'b0;
      err        <= 1'b0;
      rdData     <= '0;
      lo_byte    <= '0;
      split_word <= '0;
      split_wr   <= 1'b0;
      split_hi   <= '0;
    end else begin
      rdValid <= 1'b0;
      err     <= 1'b0;
      if (state == SPLIT) begin
        if (!split_wr) begin
          rdValid <= 1'b1;
          rdData  <= {lane_rdata[0], lo_byte};
        end
      end else if (accept) begin
        err <= illegal;
        if (misaligned) begin
          lo_byte    <= lane_rdata[1];
          split_word <= req_next;
          split_wr   <= wrEnable;
          split_hi   <= wrData[15:8];
        end else if (!wrEnable && !illegal) begin
          rdValid <= 1'b1;
          rdData  <= read_fmt;
        end
      end
    end

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed bench for banked_data_memory: aligned, byte, misaligned, wrap, illegal and reset-abort cases.
module tb_banked_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, wrEnable, rdValid, err;
  logic [1:0]  numberOfByte;
  logic [7:0]  address;
  logic [15:0] wrData, rdData;

  int n_chk  = 0;
  int n_pass = 0;

  banked_data_memory #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
    .wrEnable(wrEnable), .numberOfByte(numberOfByte), .address(address),
    .wrData(wrData), .rdData(rdData), .rdValid(rdValid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // present a request for exactly one edge; returns #1 after the accept edge
  task automatic xfer(input logic w, input logic [1:0] nb, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    reqValid = 1'b1; wrEnable = w; numberOfByte = nb; address = a; wrData = d;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] nb, input logic [7:0] a,
                    input logic [15:0] exp, input int lat);
    xfer(1'b0, nb, a, 16'h0000);
    if (lat == 2) begin
      chk({tag, "_split_rdy"}, {15'b0, reqReady}, 16'h0000);
      chk({tag, "_split_nv"},  {15'b0, rdValid},  16'h0000);
      @(posedge clk); #1;
    end
    chk({tag, "_vld"},  {15'b0, rdValid}, 16'h0001);
    chk({tag, "_data"}, rdData, exp);
  endtask

  initial begin
    rst_n = 1'b0; reqValid = 1'b0; wrEnable = 1'b0; numberOfByte = 2'b00;
    address = '0; wrData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdvalid", {15'b0, rdValid},  16'h0000);
    chk("rst_err",     {15'b0, err},      16'h0000);
    chk("rst_rddata",  rdData,            16'h0000);
    chk("rst_ready",   {15'b0, reqReady}, 16'h0001);
    @(negedge clk); rst_n = 1'b1;

    // aligned word write/read
    xfer(1'b1, 2'b00, 8'd2, 16'h1294);
    chk("wr_nvalid", {15'b0, rdValid}, 16'h0000);
    rd("rd2", 2'b00, 8'd2, 16'h1294, 1);

    // back-to-back byte reads, zero- then sign-extended
    @(negedge clk);
    reqValid = 1'b1; wrEnable = 1'b0; numberOfByte = 2'b01; address = 8'd2;
    @(posedge clk); #1;
    chk("b2b_zx",     rdData, 16'h0094);
    chk("b2b_zx_vld", {15'b0, rdValid},  16'h0001);
    chk("b2b_rdy",    {15'b0, reqReady}, 16'h0001);
    @(negedge clk); numberOfByte = 2'b10;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk("b2b_sx",     rdData, 16'h FF94);
    chk("b2b_sx_vld", {15'b0, rdValid}, 16'h0001);
    @(posedge clk); #1;
    chk("pulse_end",  {15'b0, rdValid}, 16'h0000);
    chk("hold_data",  rdData, 16'hFF94);

    // misaligned word write across words 2 and 3
    xfer(1'b1, 2'b01, 8'd4, 16'h0011);
    xfer(1'b1, 2'b00, 8'd5, 16'hABCD);
    chk("mis_wr_busy", {15'b0, reqReady}, 16'h0000);
    @(posedge clk); #1;
    chk("mis_wr_idle", {15'b0, reqReady}, 16'h0001);
    rd("mis5",  2'b00, 8'd5, 16'hABCD, 2);
    rd("b5",    2'b01, 8'd5, 16'h00CD, 1);
    rd("b6sx",  2'b10, 8'd6, 16'hFFAB, 1);
    rd("b4",    2'b01, 8'd4, 16'h0011, 1);
    rd("w4",    2'b00, 8'd4, 16'hCD11, 1);

    // wrap from byte 255 to byte 0
    xfer(1'b1, 2'b00, 8'd255, 16'h5678);
    @(posedge clk); #1;
    rd("b255",  2'b01, 8'd255, 16'h0078, 1);
    rd("b0",    2'b01, 8'd0,   16'h0056, 1);
    rd("wrap",  2'b00, 8'd255, 16'h5678, 2);

    // illegal request
    xfer(1'b1, 2'b11, 8'd2, 16'hFFFF);
    chk("ill_err",  {15'b0, err},      16'h0001);
    chk("ill_nv",   {15'b0, rdValid},  16'h0000);
    chk("ill_rdy",  {15'b0, reqReady}, 16'h0001);
    chk("ill_hold", rdData, 16'h5678);
    @(posedge clk); #1;
    chk("ill_pulse", {15'b0, err}, 16'h0000);
    rd("ill_mem", 2'b00, 8'd2, 16'h1294, 1);

    // write then read the same byte on consecutive edges
    xfer(1'b1, 2'b01, 8'd9, 16'h005A);
    rd("raw", 2'b10, 8'd9, 16'h005A, 1);

    // reset during a misaligned write
    xfer(1'b1, 2'b01, 8'd8, 16'h0033);
    xfer(1'b1, 2'b00, 8'd7, 16'hBEEF);
    rst_n = 1'b0; #1;
    chk("abort_rdy", {15'b0, reqReady}, 16'h0001);
    chk("abort_nv",  {15'b0, rdValid},  16'h0000);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdy2", {15'b0, reqReady}, 16'h0001);
    rd("abort_b7", 2'b01, 8'd7, 16'h00EF, 1);
    rd("abort_b8", 2'b01, 8'd8, 16'h0033, 1);

    // reset during a misaligned read: no result may appear
    xfer(1'b0, 2'b00, 8'd7, 16'h0000);
    rst_n = 1'b0; #1;
    chk("rabort_nv", {15'b0, rdValid}, 16'h0000);
    @(posedge clk); #1;
    chk("rabort_nv2", {15'b0, rdValid}, 16'h0000);
    chk("rabort_dat", rdData, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rabort_nv3", {15'b0, rdValid}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
